correlator_hostctrl: RTL and testbench

Byte-stream register controller between the USB-serial byte channel and the correlator datapath. It decodes host command bytes and holds the correlator configuration registers. It generates the seed, sample-period-write and fifo-flush pulses, and drains the packet fifo to the host, one byte or as a counted burst. It is the only configuration source for the correlator.

---
 rtl/correlator_pkg.sv | 24 ++
 rtl/hostctrl_txreg.sv | 36 +++
 rtl/correlator_hostctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_correlator_hostctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared definitions for the correlator host controller: register map,
// command byte layout and host-controller FSM encoding.
package correlator_pkg;

    // Command byte: bit 7 selects read, the low seven bits are the address.
    localparam int RNW_BIT = 7;

    localparam logic [6:0] ADDR_SEED  = 7'd0;
    localparam logic [6:0] ADDR_WLEN  = 7'd1;
    localparam logic [6:0] ADDR_SHAPE = 7'd2;
    localparam logic [6:0] ADDR_SPER  = 7'd3;
    localparam logic [6:0] ADDR_SJIT  = 7'd4;
    localparam logic [6:0] ADDR_PWM   = 7'd5;
    localparam logic [6:0] ADDR_PKT   = 7'd6;
    localparam logic [6:0] ADDR_FLUSH = 7'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_TX    = 2'd2,
        ST_BURST = 2'd3
    } state_e;

endpackage

// File: rtl/hostctrl_txreg.sv
// Single-entry valid/ready holding register feeding the host tx channel.
// A load overwrites the entry; the caller only loads when the entry is
// empty or is being accepted in the same cycle.
module hostctrl_txreg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [7:0] data_q;
    logic       valid_q;

    // Hold the byte until the host accepts it; a load always wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (en_i) begin
            if (load_i) begin
                data_q  <= load_data_i;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/correlator_hostctrl.sv
// Host byte-stream register controller: decodes command bytes, holds the
// correlator configuration, emits seed/sample-period/flush pulses and drains
// the packet fifo to the host as single reads or counted bursts.
module correlator_hostctrl
    import correlator_pkg::*;
#(
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int MAX_SAMPLE_PERIOD_EXP = 15,
    parameter int MAX_SAMPLE_JITTER_EXP = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cg,
    input  logic [7:0] i_hostRx_data,
    input  logic i_hostRx_valid,
    output logic o_hostRx_ready,
    output logic [7:0] o_hostTx_data,
    output logic o_hostTx_valid,
    input  logic i_hostTx_ready,
    input  logic [7:0] i_pktfifo_data,
    input  logic i_pktfifo_empty,
    output logic o_pktfifo_pop,
    output logic o_pktfifo_flush,
    output logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] o_windowLengthExp,
    output logic o_windowShape,
    output logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0] o_samplePeriodExp,
    output logic [$clog2(MAX_SAMPLE_JITTER_EXP+1)-1:0] o_sampleJitterExp,
    output logic [2:0] o_pwmSelect,
    output logic o_wr_samplePeriod,
    output logic [7:0] o_jitterSeedByte,
    output logic o_jitterSeedValid
);

    localparam int WL_W = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
    localparam int SP_W = $clog2(MAX_SAMPLE_PERIOD_EXP + 1);
    localparam int SJ_W = $clog2(MAX_SAMPLE_JITTER_EXP + 1);

    state_e          state_q, state_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      count_q, count_d;
    logic            rx_ready_q;
    logic [WL_W-1:0] wl_q;
    logic            shape_q;
    logic [SP_W-1:0] sp_q;
    logic [SJ_W-1:0] sj_q;
    logic [2:0]      pwm_q;
    logic [7:0]      seed_byte_q;
    logic            seed_valid_q, wr_sp_q, flush_q;

    logic            rx_ready_s, rx_accept_s, tx_valid_s, tx_free_s;
    logic            wr_en_s, load_s, pop_s;
    logic [7:0]      load_data_s, rd_data_s;
    logic [WL_W-1:0] wl_sat_s;
    logic [SP_W-1:0] sp_sat_s;
    logic [SJ_W-1:0] sj_sat_s;

    // Nothing is accepted while the clock gate is closed.
    assign rx_ready_s  = rx_ready_q & i_cg;
    assign rx_accept_s = i_hostRx_valid & rx_ready_s;
    assign tx_free_s   = ~tx_valid_s | i_hostTx_ready;

    assign wl_sat_s = (int'(i_hostRx_data) > MAX_WINDOW_LENGTH_EXP) ?
                      WL_W'(MAX_WINDOW_LENGTH_EXP) : WL_W'(i_hostRx_data);
    assign sp_sat_s = (int'(i_hostRx_data) > MAX_SAMPLE_PERIOD_EXP) ?
                      SP_W'(MAX_SAMPLE_PERIOD_EXP) : SP_W'(i_hostRx_data);
    assign sj_sat_s = (int'(i_hostRx_data) > MAX_SAMPLE_JITTER_EXP) ?
                      SJ_W'(MAX_SAMPLE_JITTER_EXP) : SJ_W'(i_hostRx_data);

    // Read-back mux for single reads; PKT returns the fifo head or zero when empty.
    always_comb begin
        rd_data_s = 8'h00;
        case (addr_q)
            ADDR_WLEN:  rd_data_s = 8'(wl_q);
            ADDR_SHAPE: rd_data_s = {7'd0, shape_q};
            ADDR_SPER:  rd_data_s = 8'(sp_q);
            ADDR_SJIT:  rd_data_s = 8'(sj_q);
            ADDR_PWM:   rd_data_s = {5'd0, pwm_q};
            ADDR_PKT:   rd_data_s = i_pktfifo_empty ? 8'h00 : i_pktfifo_data;
            default:    rd_data_s = 8'h00;
        endcase
    end

    // Command FSM next-state, tx-register load and fifo pop decisions.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        wr_en_s     = 1'b0;
        load_s      = 1'b0;
        load_data_s = 8'h00;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_accept_s) begin
                    addr_d  = i_hostRx_data[RNW_BIT-1:0];
                    state_d = i_hostRx_data[RNW_BIT] ? ST_TX : ST_WDATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (rx_accept_s) begin
                    wr_en_s = 1'b1;
                    if ((addr_q == ADDR_PKT) && (i_hostRx_data != 8'h00)) begin
                        state_d = ST_BURST;
                        count_d = i_hostRx_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_TX: begin
                // The tx register is always empty on entry, so the first
                // cycle loads and later cycles wait for the host.
                if (!tx_valid_s) begin
                    load_s      = 1'b1;
                    load_data_s = rd_data_s;
                    pop_s       = (addr_q == ADDR_PKT) && !i_pktfifo_empty;
                end else if (i_hostTx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TX;
                end
            end
            ST_BURST: begin
                if (count_q != 8'd0) begin
                    if (tx_free_s && !i_pktfifo_empty) begin
                        load_s      = 1'b1;
                        load_data_s = i_pktfifo_data;
                        pop_s       = 1'b1;
                        count_d     = count_q - 8'd1;
                    end else begin
                        load_s = 1'b0;
                    end
                end else if (tx_free_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, configuration registers and one-cycle pulses; frozen when i_cg is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= 7'd0;
            count_q      <= 8'd0;
            rx_ready_q   <= 1'b0;
            wl_q         <= '0;
            shape_q      <= 1'b0;
            sp_q         <= '0;
            sj_q         <= '0;
            pwm_q        <= 3'd0;
            seed_byte_q  <= 8'h00;
            seed_valid_q <= 1'b0;
            wr_sp_q      <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            seed_valid_q <= 1'b0;
            wr_sp_q      <= 1'b0;
            flush_q      <= 1'b0;
            if (i_cg) begin
                state_q    <= state_d;
                addr_q     <= addr_d;
                count_q    <= count_d;
                rx_ready_q <= (state_d == ST_IDLE) || (state_d == ST_WDATA);
                if (wr_en_s) begin
                    case (addr_q)
                        ADDR_SEED: begin
                            seed_byte_q  <= i_hostRx_data;
                            seed_valid_q <= 1'b1;
                        end
                        ADDR_WLEN:  wl_q    <= wl_sat_s;
                        ADDR_SHAPE: shape_q <= i_hostRx_data[0];
                        ADDR_SPER: begin
                            sp_q    <= sp_sat_s;
                            wr_sp_q <= 1'b1;
                        end
                        ADDR_SJIT:  sj_q    <= sj_sat_s;
                        ADDR_PWM:   pwm_q   <= i_hostRx_data[2:0];
                        ADDR_FLUSH: flush_q <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    hostctrl_txreg u_txreg (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .en_i        (i_cg),
        .load_i      (load_s),
        .load_data_i (load_data_s),
        .ready_i     (i_hostTx_ready),
        .data_o      (o_hostTx_data),
        .valid_o     (tx_valid_s)
    );

    assign o_hostTx_valid    = tx_valid_s;
    assign o_hostRx_ready    = rx_ready_s;
    assign o_pktfifo_pop     = pop_s & i_cg;
    assign o_pktfifo_flush   = flush_q;
    assign o_windowLengthExp = wl_q;
    assign o_windowShape     = shape_q;
    assign o_samplePeriodExp = sp_q;
    assign o_sampleJitterExp = sj_q;
    assign o_pwmSelect       = pwm_q;
    assign o_wr_samplePeriod = wr_sp_q;
    assign o_jitterSeedByte  = seed_byte_q;
    assign o_jitterSeedValid = seed_valid_q;

endmodule

// File: tb/tb_correlator_hostctrl.sv
// Self-checking bench for correlator_hostctrl: directed host transactions
// plus randomized register traffic checked against a register/fifo model.
module tb_correlator_hostctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cg = 1'b1;
    logic [7:0] i_hostRx_data = 8'h00;
    logic       i_hostRx_valid = 1'b0;
    logic       o_hostRx_ready;
    logic [7:0] o_hostTx_data;
    logic       o_hostTx_valid;
    logic       i_hostTx_ready = 1'b1;
    logic [7:0] i_pktfifo_data = 8'h00;
    logic       i_pktfifo_empty = 1'b1;
    logic       o_pktfifo_pop, o_pktfifo_flush;
    logic [4:0] o_windowLengthExp;
    logic       o_windowShape;
    logic [3:0] o_samplePeriodExp;
    logic [3:0] o_sampleJitterExp;
    logic [2:0] o_pwmSelect;
    logic       o_wr_samplePeriod;
    logic [7:0] o_jitterSeedByte;
    logic       o_jitterSeedValid;

    correlator_hostctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
        .i_hostRx_data(i_hostRx_data), .i_hostRx_valid(i_hostRx_valid),
        .o_hostRx_ready(o_hostRx_ready),
        .o_hostTx_data(o_hostTx_data), .o_hostTx_valid(o_hostTx_valid),
        .i_hostTx_ready(i_hostTx_ready),
        .i_pktfifo_data(i_pktfifo_data), .i_pktfifo_empty(i_pktfifo_empty),
        .o_pktfifo_pop(o_pktfifo_pop), .o_pktfifo_flush(o_pktfifo_flush),
        .o_windowLengthExp(o_windowLengthExp), .o_windowShape(o_windowShape),
        .o_samplePeriodExp(o_samplePeriodExp), .o_sampleJitterExp(o_sampleJitterExp),
        .o_pwmSelect(o_pwmSelect), .o_wr_samplePeriod(o_wr_samplePeriod),
        .o_jitterSeedByte(o_jitterSeedByte), .o_jitterSeedValid(o_jitterSeedValid)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int         mdl[8];
    logic [7:0] mdl_seed;

    // Output monitor state
    int         cyc = 0;
    int         pop_cnt = 0, seed_cnt = 0, wrsp_cnt = 0, flush_cnt = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    logic [7:0] seed_seen = 8'h00;
    logic [3:0] sp_at_pulse = 4'd0;
    int         rd_idx = 0;
    logic       bp = 1'b0;

    // External packet fifo model
    logic [7:0] push_data[0:255];
    int         push_cnt = 0;
    int         push_done = 0;
    logic [7:0] fifo[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor handshakes and pulses at each active edge.
    always @(posedge i_clk) begin
        cyc++;
        if (o_hostTx_valid && i_hostTx_ready) begin
            tx_log.push_back(o_hostTx_data);
            tx_cyc.push_back(cyc);
        end
        if (o_pktfifo_pop) pop_cnt++;
        if (o_jitterSeedValid) begin seed_cnt++; seed_seen = o_jitterSeedByte; end
        if (o_wr_samplePeriod) begin wrsp_cnt++; sp_at_pulse = o_samplePeriodExp; end
        if (o_pktfifo_flush) flush_cnt++;
    end

    // Fifo: apply the pop seen at this edge, then append pending pushes.
    always @(posedge i_clk) begin
        logic pop_now;
        pop_now = o_pktfifo_pop;
        #1;
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        while (push_done < push_cnt) begin
            fifo.push_back(push_data[push_done]);
            push_done++;
        end
        i_pktfifo_empty = (fifo.size() == 0);
        i_pktfifo_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic push(input logic [7:0] b);
        push_data[push_cnt[7:0]] = b;
        push_cnt++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mdl[k] = 0;
        mdl_seed = 8'h00;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'd0: mdl_seed = d;
            7'd1: mdl[1] = (d > 16) ? 16 : int'(d);
            7'd2: mdl[2] = int'(d) % 2;
            7'd3: mdl[3] = (d > 15) ? 15 : int'(d);
            7'd4: mdl[4] = (d > 8) ? 8 : int'(d);
            7'd5: mdl[5] = int'(d) % 8;
            default: ;
        endcase
    endtask

    function automatic int model_read(input logic [6:0] a);
        return (a >= 7'd1 && a <= 7'd5) ? mdl[a[2:0]] : 0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (!o_hostRx_ready && w < 100) begin @(negedge i_clk); w++; end
        chk("rx_ready", 32'(o_hostRx_ready), 32'd1);
        i_hostRx_data  = b;
        i_hostRx_valid = 1'b1;
        @(negedge i_clk);
        i_hostRx_valid = 1'b0;
    endtask

    task automatic recv(output logic [7:0] b);
        int w = 0;
        while (tx_log.size() <= rd_idx && w < 200) begin
            i_hostTx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge i_clk);
            w++;
        end
        i_hostTx_ready = 1'b1;
        chk("tx_byte_arrived", 32'(tx_log.size() > rd_idx), 32'd1);
        if (tx_log.size() > rd_idx) begin b = tx_log[rd_idx]; rd_idx++; end
        else b = 8'hEE;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        send_byte({1'b0, a});
        send_byte(d);
        model_write(a, d);
    endtask

    task automatic do_read(input logic [6:0] a, input string tag);
        logic [7:0] b;
        send_byte({1'b1, a});
        recv(b);
        chk(tag, 32'(b), 32'(model_read(a)));
    endtask

    task automatic check_cfg(input string tag);
        chk({tag, "_wl"},   32'(o_windowLengthExp), 32'(mdl[1]));
        chk({tag, "_shape"}, 32'(o_windowShape),    32'(mdl[2]));
        chk({tag, "_sp"},   32'(o_samplePeriodExp), 32'(mdl[3]));
        chk({tag, "_sj"},   32'(o_sampleJitterExp), 32'(mdl[4]));
        chk({tag, "_pwm"},  32'(o_pwmSelect),       32'(mdl[5]));
        chk({tag, "_seed"}, 32'(o_jitterSeedByte),  32'(mdl_seed));
    endtask

    initial begin
        logic [7:0] b, d;
        logic [6:0] a;
        logic [7:0] exp_q[$];
        int s0, w0, f0, p0, t0, base, k, w;

        model_reset();
        // Reset state
        tick(3);
        chk("rst_tx_valid", 32'(o_hostTx_valid), 32'd0);
        chk("rst_rx_ready", 32'(o_hostRx_ready), 32'd0);
        chk("rst_pulses", 32'({o_jitterSeedValid, o_wr_samplePeriod, o_pktfifo_flush, o_pktfifo_pop}), 32'd0);
        check_cfg("rst");
        i_rst = 1'b0;
        tick(2);
        chk("idle_rx_ready", 32'(o_hostRx_ready), 32'd1);

        // windowLengthExp write then read back
        do_write(7'd1, 8'h0A);
        chk("wl_after_write", 32'(o_windowLengthExp), 32'd10);
        do_read(7'd1, "read_wl");

        // samplePeriodExp saturates and pulses once alongside the update
        w0 = wrsp_cnt;
        do_write(7'd3, 8'hFF);
        tick(2);
        chk("sp_saturated", 32'(o_samplePeriodExp), 32'd15);
        chk("wrsp_one_cycle", 32'(wrsp_cnt - w0), 32'd1);
        chk("sp_at_pulse", 32'(sp_at_pulse), 32'd15);
        do_read(7'd3, "read_sp");

        // Seed strobe and zero read-back
        s0 = seed_cnt;
        do_write(7'd0, 8'hA5);
        tick(2);
        chk("seed_one_cycle", 32'(seed_cnt - s0), 32'd1);
        chk("seed_byte_at_strobe", 32'(seed_seen), 32'hA5);
        do_read(7'd0, "read_seed");

        // Three-byte burst at full rate
        push(8'h11); push(8'h22); push(8'h33);
        tick(2);
        p0 = pop_cnt; base = rd_idx;
        do_write(7'd6, 8'd3);
        recv(b); chk("burst3_b0", 32'(b), 32'h11);
        recv(b); chk("burst3_b1", 32'(b), 32'h22);
        recv(b); chk("burst3_b2", 32'(b), 32'h33);
        chk("burst3_gap01", 32'(tx_cyc[base+1] - tx_cyc[base]), 32'd1);
        chk("burst3_gap12", 32'(tx_cyc[base+2] - tx_cyc[base+1]), 32'd1);
        tick(2);
        chk("burst3_pops", 32'(pop_cnt - p0), 32'd3);
        chk("burst3_back_idle", 32'(o_hostRx_ready), 32'd1);

        // Burst of zero transfers nothing
        p0 = pop_cnt; t0 = tx_log.size();
        do_write(7'd6, 8'd0);
        tick(3);
        chk("burst0_pops", 32'(pop_cnt - p0), 32'd0);
        chk("burst0_no_tx", 32'(tx_log.size() - t0), 32'd0);
        chk("burst0_idle", 32'(o_hostRx_ready), 32'd1);

        // Random register traffic
        for (int i = 0; i < 30; i++) begin
            a = 7'($urandom_range(0, 9));
            if (a == 7'd6) a = 7'($urandom_range(8, 127));
            d = 8'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                s0 = seed_cnt; w0 = wrsp_cnt; f0 = flush_cnt;
                do_write(a, d);
                tick(2);
                check_cfg("rnd");
                chk("rnd_seed_pulses", 32'(seed_cnt - s0), (a == 7'd0) ? 32'd1 : 32'd0);
                chk("rnd_wrsp_pulses", 32'(wrsp_cnt - w0), (a == 7'd3) ? 32'd1 : 32'd0);
                chk("rnd_flush_pulses", 32'(flush_cnt - f0), (a == 7'd7) ? 32'd1 : 32'd0);
            end else begin
                do_read(a, "rnd_read");
            end
        end

        // Random burst under random host backpressure
        k = $urandom_range(3, 8);
        exp_q.delete();
        for (int i = 0; i < k; i++) begin
            d = 8'($urandom);
            push(d);
            exp_q.push_back(d);
        end
        tick(2);
        p0 = pop_cnt;
        do_write(7'd6, 8'(k));
        bp = 1'b1;
        for (int i = 0; i < k; i++) begin
            recv(b);
            chk("bp_burst_byte", 32'(b), 32'(exp_q[i]));
        end
        bp = 1'b0;
        tick(3);
        chk("bp_burst_pops", 32'(pop_cnt - p0), 32'(k));
        chk("bp_burst_idle", 32'(o_hostRx_ready), 32'd1);

        // Burst of 4 with only 2 bytes available: stall, resume, then reset
        push(8'h44); push(8'h55);
        tick(2);
        do_write(7'd6, 8'd4);
        recv(b); chk("stall_b0", 32'(b), 32'h44);
        recv(b); chk("stall_b1", 32'(b), 32'h55);
        tick(10);
        chk("stall_valid_low", 32'(o_hostTx_valid), 32'd0);
        chk("stall_rx_blocked", 32'(o_hostRx_ready), 32'd0);
        tick(10);
        chk("stall_valid_low2", 32'(o_hostTx_valid), 32'd0);
        chk("stall_rx_blocked2", 32'(o_hostRx_ready), 32'd0);
        i_hostTx_ready = 1'b0;
        push(8'h66);
        w = 0;
        while (!o_hostTx_valid && w < 50) begin @(negedge i_clk); w++; end
        chk("resume_valid", 32'(o_hostTx_valid), 32'd1);
        chk("resume_data", 32'(o_hostTx_data), 32'h66);
        i_rst = 1'b1;
        #1;
        chk("midburst_rst_valid", 32'(o_hostTx_valid), 32'd0);
        chk("midburst_rst_ready", 32'(o_hostRx_ready), 32'd0);
        model_reset();
        tick(2);
        i_rst = 1'b0;
        i_hostTx_ready = 1'b1;
        tick(2);
        chk("post_rst_ready", 32'(o_hostRx_ready), 32'd1);
        check_cfg("post_rst");
        p0 = pop_cnt; t0 = tx_log.size();
        push(8'h77);
        tick(10);
        chk("post_rst_no_pop", 32'(pop_cnt - p0), 32'd0);
        chk("post_rst_no_tx", 32'(tx_log.size() - t0), 32'd0);
        do_write(7'd5, 8'hFE);
        chk("post_rst_cmd", 32'(o_pwmSelect), 32'd6);

        // Single PKT reads: one byte, then empty
        p0 = pop_cnt;
        send_byte(8'h86);
        recv(b);
        chk("pkt_read_byte", 32'(b), 32'h77);
        tick(2);
        chk("pkt_read_pop", 32'(pop_cnt - p0), 32'd1);
        p0 = pop_cnt;
        send_byte(8'h86);
        recv(b);
        chk("pkt_empty_read", 32'(b), 32'h00);
        tick(2);
        chk("pkt_empty_no_pop", 32'(pop_cnt - p0), 32'd0);

        // Flush pulse
        f0 = flush_cnt;
        do_write(7'd7, 8'h00);
        tick(2);
        chk("flush_one_cycle", 32'(flush_cnt - f0), 32'd1);

        // Clock gate closes the rx channel
        i_cg = 1'b0;
        tick(1);
        chk("cg_rx_ready", 32'(o_hostRx_ready), 32'd0);
        i_cg = 1'b1;
        tick(1);
        chk("cg_release_ready", 32'(o_hostRx_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
